inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/nq_loader_pkg.sv | 25 ++
 rtl/inst_loader_byte_packer.sv | 56 +++++
 rtl/inst_loader.sv | 188 ++++++++++++++++++
 tb/tb_inst_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nq_loader_pkg.sv
// rtl/nq_loader_pkg.sv - shared types and widths for the instruction loader
//
// Purpose : FSM state encoding and datapath widths used by inst_loader and
//           byte_packer.
// Contents: WORD_W  - instruction word width (32)
//           BYTE_W  - host byte width (8)
//           CNT_W   - word count / header total width (16)
//           state_t - loader FSM states
package nq_loader_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR_LO  = 3'd1,
      HDR_HI  = 3'd2,
      COLLECT = 3'd3,
      WRITE   = 3'd4,
      CHK     = 3'd5,
      DONE    = 3'd6
   } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// rtl/inst_loader_byte_packer.sv - packs four host bytes into one 32-bit word
//
// Purpose : Little-endian byte packer. The first three bytes of a word are
//           staged in an accumulator; the fourth byte completes the word and
//           moves it to the output register in one step, so o_word only
//           changes when a full word is ready and otherwise holds its value.
// Ports   : clk         - clock, rising edge
//           rst         - asynchronous active-high reset
//           i_clr       - restart at byte index 0 (new session)
//           i_byte_en   - accept i_byte at the current byte index
//           i_byte      - byte to insert
//           o_word      - last completed word
//           o_word_full - high in the cycle the fourth byte is accepted
module byte_packer
   import nq_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_byte_en,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_full
);

   logic [1:0]               r_idx;
   logic [WORD_W-BYTE_W-1:0] r_acc;
   logic [WORD_W-1:0]        r_word;
   logic                     w_last;

   assign w_last      = (r_idx == 2'd3);
   assign o_word_full = i_byte_en & w_last;
   assign o_word      = r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx  <= 2'd0;
         r_acc  <= '0;
         r_word <= '0;
      end else if (i_clr) begin
         // r_word is deliberately kept: the instruction port holds its value
         r_idx <= 2'd0;
         r_acc <= '0;
      end else if (i_byte_en) begin
         // two-bit index wraps 3 -> 0 on its own
         r_idx <= r_idx + 2'd1;
         case (r_idx)
            2'd0:    r_acc[7:0]   <= i_byte;
            2'd1:    r_acc[15:8]  <= i_byte;
            2'd2:    r_acc[23:16] <= i_byte;
            default: r_word       <= {i_byte, r_acc};
         endcase
      end
   end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - host byte stream to processor instruction port loader
//
// Purpose : Receives a 16-bit little-endian word count followed by that many
//           little-endian 32-bit words, presents each word on exInst with a
//           one-cycle write strobe, and holds the processor in reset until
//           the load completes.
// Option  : LOADER_CHECKSUM_EN - adds a trailer byte after the data; the
//           modulo-256 sum of header, data and trailer must be zero, else
//           err is set and cpu_rst stays asserted.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous active-high reset
//           start      - one-cycle pulse, begins a session from IDLE/DONE
//           byte_in    - host byte
//           byte_valid - host byte valid
//           byte_ready - loader can accept a byte this cycle
//           exInst     - assembled instruction word
//           write      - exInst write strobe
//           cpu_rst    - processor reset
//           busy       - session in progress
//           done       - load complete, held until next start
//           word_cnt   - words written this session
//           err        - checksum mismatch
module inst_loader
   import nq_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [WORD_W-1:0] exInst,
   output logic              write,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              err
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t AFTER_LAST = CHK;
`else
   localparam state_t AFTER_LAST = DONE;
`endif

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_total;
   logic [CNT_W-1:0]  r_word_cnt;
   logic [CNT_W-1:0]  w_hdr_total;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_xfer;
   logic              w_start_ok;
   logic              w_pack_en;
   logic              w_word_full;
   logic              w_last_word;
   logic              w_err;
   logic [WORD_W-1:0] w_word;

   assign w_xfer      = byte_valid & byte_ready;
   assign w_start_ok  = start & ((r_state == IDLE) | (r_state == DONE));
   assign w_pack_en   = w_xfer & (r_state == COLLECT);
   // the high header byte is still on byte_in when the zero test is made
   assign w_hdr_total = {byte_in, r_total[7:0]};
   // saturating increment keeps word_cnt from ever passing total
   assign w_cnt_inc   = (r_word_cnt == r_total) ? r_word_cnt : r_word_cnt + 16'd1;
   assign w_last_word = (w_cnt_inc == r_total);

   byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_start_ok),
      .i_byte_en   (w_pack_en),
      .i_byte      (byte_in),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start) w_next = HDR_LO;
         end
         HDR_LO: begin
            if (w_xfer) w_next = HDR_HI;
         end
         HDR_HI: begin
            if (w_xfer) w_next = (w_hdr_total != '0) ? COLLECT : AFTER_LAST;
         end
         COLLECT: begin
            if (w_word_full) w_next = WRITE;
         end
         WRITE: begin
            w_next = w_last_word ? AFTER_LAST : COLLECT;
         end
         CHK: begin
            if (w_xfer) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // output logic
   always_comb begin
      byte_ready = 1'b0;
      write      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
         end
         HDR_LO, HDR_HI, COLLECT, CHK: begin
            byte_ready = 1'b1;
         end
         WRITE: begin
            write = 1'b1;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      cpu_rst = ~((r_state == DONE) & ~w_err);
   end

   // header capture and word counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total    <= '0;
         r_word_cnt <= '0;
      end else begin
         if (w_start_ok) begin
            r_total    <= '0;
            r_word_cnt <= '0;
         end
         if (w_xfer && (r_state == HDR_LO)) r_total[7:0]  <= byte_in;
         if (w_xfer && (r_state == HDR_HI)) r_total[15:8] <= byte_in;
         if (r_state == WRITE)              r_word_cnt    <= w_cnt_inc;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] r_sum;
   logic [BYTE_W-1:0] w_sum_trl;
   logic              r_err;

   assign w_sum_trl = r_sum + byte_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_start_ok) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_xfer) begin
         // the trailer is not summed: it is the byte that should zero the sum
         if (r_state == CHK) r_err <= (w_sum_trl != '0);
         else                r_sum <= w_sum_trl;
      end
   end

   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   assign err      = w_err;
   assign exInst   = w_word;
   assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - self-checking bench for inst_loader
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [31:0] exInst;
   logic        write;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic [15:0] word_cnt;
   logic        err;

   int n_tot = 0;
   int n_bad = 0;

   logic [7:0]  q_bytes[$];
   logic [31:0] got_words[$];
   logic [31:0] exp_words[$];
   int          exp_total;
   bit          exp_err;
   bit          finished;
   int          cyc_done;

   inst_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .exInst     (exInst),
      .write      (write),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .word_cnt   (word_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Reference model: words are consecutive 4-byte little-endian groups after
   // the 2-byte count; err is a nonzero byte sum over the whole stream.
   task automatic build_expect();
      logic [7:0] s;
      exp_words.delete();
      exp_total = {q_bytes[1], q_bytes[0]};
      for (int w = 0; w < exp_total; w++)
         exp_words.push_back({q_bytes[2+4*w+3], q_bytes[2+4*w+2],
                              q_bytes[2+4*w+1], q_bytes[2+4*w]});
      s = 8'h00;
      foreach (q_bytes[i]) s = s + q_bytes[i];
`ifdef LOADER_CHECKSUM_EN
      exp_err = (s != 8'h00);
`else
      exp_err = 1'b0;
`endif
   endtask

   task automatic make_load(input int total, input bit bad_trailer);
      logic [7:0] s;
      q_bytes.delete();
      q_bytes.push_back(8'(total));
      q_bytes.push_back(8'(total >> 8));
      for (int i = 0; i < 4 * total; i++) q_bytes.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      s = 8'h00;
      foreach (q_bytes[i]) s = s + q_bytes[i];
      q_bytes.push_back(bad_trailer ? 8'(8'h00 - s + 8'(1 + $urandom_range(254))) : 8'(8'h00 - s));
`else
      if (bad_trailer) s = 8'h00;
`endif
      build_expect();
   endtask

   // pct < 0: byte_valid toggles every cycle
   task automatic run_load(input int pct, input int poke_idx, input int abort_idx);
      int  idx;
      bit  poked;
      logic [15:0] cnt_before;
      idx = 0;
      poked = 0;
      finished = 0;
      cyc_done = -1;
      got_words.delete();
      @(negedge clk);
      start = 1'b1;
      byte_valid = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            finished = 1;
            cyc_done = c;
            break;
         end
         if (write) begin
            got_words.push_back(exInst);
            n_tot++;
            if (byte_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL ready_in_write got=%b want=0", byte_ready);
            end
         end
         if (abort_idx >= 0 && idx == abort_idx) begin
            byte_valid = 1'b0;
            rst = 1'b1;
            #1;
            n_tot++;
            if (busy !== 1'b0 || cpu_rst !== 1'b1) begin
               n_bad++;
               $display("FAIL abort_now busy=%b cpu_rst=%b want 0/1", busy, cpu_rst);
            end
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (!poked && poke_idx >= 0 && idx == poke_idx) begin
            poked = 1;
            cnt_before = word_cnt;
            start = 1'b1;
            byte_valid = 1'b0;
            @(negedge clk);
            start = 1'b0;
            n_tot++;
            if (word_cnt !== cnt_before || busy !== 1'b1 || byte_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL start_ignored word_cnt=%0d want=%0d busy=%b ready=%b",
                        word_cnt, cnt_before, busy, byte_ready);
            end
            continue;
         end
         if (pct < 0) byte_valid = (idx < q_bytes.size()) && (c % 2 == 0);
         else         byte_valid = (idx < q_bytes.size()) && ($urandom_range(99) < pct);
         byte_in = byte_valid ? q_bytes[idx] : 8'($urandom);
         #1;
         if (byte_valid && byte_ready) idx++;
      end
      byte_valid = 1'b0;
      if (!finished) begin
         n_tot++;
         n_bad++;
         $display("FAIL timeout done=%b want=1", done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tot++;
      if ({byte_ready, write, busy, done, err, cpu_rst} !== 6'b000001 ||
          exInst !== 32'h0 || word_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL reset rdy/wr/busy/done/err/cpu=%b exInst=%h cnt=%0d want 000001/0/0",
                  {byte_ready, write, busy, done, err, cpu_rst}, exInst, word_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] s;
      q_bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
      s = 8'h00;
      foreach (q_bytes[i]) s = s + q_bytes[i];
      q_bytes.push_back(8'h00 - s);
`else
      s = 8'h00;
`endif
      run_load(100, -1, -1);
      n_tot++;
      if (got_words.size() != 2 || got_words[0] !== 32'h12345678 || got_words[1] !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL basic_words n=%0d w0=%h w1=%h want 2/12345678/deadbeef",
                  got_words.size(), got_words.size() > 0 ? got_words[0] : 32'h0,
                  got_words.size() > 1 ? got_words[1] : 32'h0);
      end
      n_tot++;
      if (word_cnt !== 16'd2 || done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_status cnt=%0d done=%b cpu_rst=%b busy=%b err=%b want 2/1/0/0/0",
                  word_cnt, done, cpu_rst, busy, err);
      end
      n_tot++;
      if (cyc_done != q_bytes.size() + 2) begin
         n_bad++;
         $display("FAIL basic_rate cycles=%0d want=%0d", cyc_done, q_bytes.size() + 2);
      end
   endtask

   task automatic test_zero_header();
      q_bytes = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      q_bytes.push_back(8'h00);
`endif
      run_load(100, -1, -1);
      n_tot++;
      if (got_words.size() != 0 || done !== 1'b1 || word_cnt !== 16'd0 || cpu_rst !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_hdr writes=%0d done=%b cnt=%0d cpu_rst=%b want 0/1/0/0",
                  got_words.size(), done, word_cnt, cpu_rst);
      end
      n_tot++;
      if (cyc_done != q_bytes.size()) begin
         n_bad++;
         $display("FAIL zero_hdr_latency cycles=%0d want=%0d", cyc_done, q_bytes.size());
      end
   endtask

   task automatic test_throttled();
      make_load(1, 1'b0);
      run_load(-1, -1, -1);
      n_tot++;
      if (got_words.size() != 1 || got_words[0] !== exp_words[0] || word_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL throttled n=%0d w=%h want 1/%h cnt=%0d",
                  got_words.size(), got_words.size() > 0 ? got_words[0] : 32'h0, exp_words[0], word_cnt);
      end
      n_tot++;
      if (exInst !== exp_words[0] || write !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_exInst got=%h write=%b want %h/0", exInst, write, exp_words[0]);
      end
   endtask

   task automatic test_abort();
      make_load(1, 1'b0);
      run_load(100, -1, 4);
      n_tot++;
      if (got_words.size() != 0 || busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1 ||
          word_cnt !== 16'd0 || exInst !== 32'h0 || byte_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL abort writes=%0d busy=%b done=%b cpu_rst=%b cnt=%0d exInst=%h rdy=%b",
                  got_words.size(), busy, done, cpu_rst, word_cnt, exInst, byte_ready);
      end
      make_load(1, 1'b0);
      run_load(100, -1, -1);
      n_tot++;
      if (got_words.size() != 1 || got_words[0] !== exp_words[0] || done !== 1'b1 || cpu_rst !== 1'b0) begin
         n_bad++;
         $display("FAIL after_abort n=%0d done=%b cpu_rst=%b want 1/1/0", got_words.size(), done, cpu_rst);
      end
   endtask

   task automatic test_start_ignored();
      make_load(2, 1'b0);
      run_load(100, 8, -1);
      n_tot++;
      if (got_words.size() != 2 || got_words[0] !== exp_words[0] || got_words[1] !== exp_words[1] ||
          word_cnt !== 16'd2) begin
         n_bad++;
         $display("FAIL poke_words n=%0d cnt=%0d want 2/2", got_words.size(), word_cnt);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      q_bytes = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE};
      run_load(100, -1, -1);
      n_tot++;
      if (err !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
         n_bad++;
         $display("FAIL chk_good err=%b done=%b cpu_rst=%b want 0/1/0", err, done, cpu_rst);
      end
      q_bytes = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
      run_load(100, -1, -1);
      n_tot++;
      if (err !== 1'b1 || done !== 1'b1 || cpu_rst !== 1'b1) begin
         n_bad++;
         $display("FAIL chk_bad err=%b done=%b cpu_rst=%b want 1/1/1", err, done, cpu_rst);
      end
   endtask
`endif

   task automatic test_random();
      int nw;
      for (int k = 0; k < 8; k++) begin
         nw = $urandom_range(5, 1);
         make_load(nw, ($urandom_range(3) == 0));
         run_load($urandom_range(100, 40), -1, -1);
         n_tot++;
         if (got_words.size() != exp_words.size()) begin
            n_bad++;
            $display("FAIL rand_count load=%0d got=%0d want=%0d", k, got_words.size(), exp_words.size());
         end else begin
            foreach (exp_words[i]) begin
               n_tot++;
               if (got_words[i] !== exp_words[i]) begin
                  n_bad++;
                  $display("FAIL rand_word load=%0d idx=%0d got=%h want=%h", k, i, got_words[i], exp_words[i]);
               end
            end
         end
         n_tot++;
         if (word_cnt !== 16'(exp_total) || err !== exp_err || cpu_rst !== exp_err || done !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_status load=%0d cnt=%0d err=%b cpu_rst=%b done=%b want %0d/%b/%b/1",
                     k, word_cnt, err, cpu_rst, done, exp_total, exp_err, exp_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_header();
      test_throttled();
      test_abort();
      test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
